// File: rtl/cipher_pkg.sv
// Shared cipher definitions: block geometry and fetch-sequencer state encoding.
// The cipher core's input stage imports the same state type.
package cipher_pkg;

  localparam int unsigned BLOCK_W       = 64;
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned BYTES_PER_BLK = 8;
  localparam int unsigned BYTE_CNT_W    = $clog2(BYTES_PER_BLK);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_PRESENT = 3'd3,
    ST_FINISH  = 3'd4
  } fetch_state_e;

  function automatic logic is_last_byte(input logic [BYTE_CNT_W-1:0] cnt);
    return cnt == BYTE_CNT_W'(BYTES_PER_BLK - 1);
  endfunction

endpackage

// File: rtl/block_fetch_ctrl_if.sv
// Memory read bus and block valid/ready handshake between fetch sequencer,
// text memory and cipher core.
interface block_fetch_ctrl_if
  import cipher_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
);

  logic                mem_rd;
  logic [ADDR_W-1:0]   mem_addr;
  logic [BYTE_W-1:0]   mem_data;
  logic [BLOCK_W-1:0]  blk_data;
  logic                blk_valid;
  logic                blk_ready;

  modport master (
    output mem_rd, mem_addr, blk_data, blk_valid,
    input  mem_data, blk_ready
  );

  modport slave (
    input  mem_rd, mem_addr, blk_data, blk_valid,
    output mem_data, blk_ready
  );

endinterface

// File: rtl/byte_shift_assembler.sv
// Shifts bytes in at the LSB end so the first byte read ends up in the MSBs.
module byte_shift_assembler
  import cipher_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               shift_en,
  input  logic [BYTE_W-1:0]  din,
  input  logic               clr,
  output logic [BLOCK_W-1:0] dout
);

  logic [BLOCK_W-1:0] asm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q <= '0;
    end else if (clr) begin
      asm_q <= '0;
    end else if (shift_en) begin
      asm_q <= {asm_q[BLOCK_W-BYTE_W-1:0], din};
    end
  end

  assign dout = asm_q;

endmodule

// File: rtl/block_fetch_ctrl.sv
// Fetches num_blocks 8-byte blocks from byte memory and presents each as a
// 64-bit word over valid/ready; pulses done after the last accepted block.
module block_fetch_ctrl
  import cipher_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 8
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    num_blocks,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  block_fetch_ctrl_if.master  bus
);

  fetch_state_e            state_q, state_d;
  logic [ADDR_W-1:0]       cur_addr_q, cur_addr_d;
  logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]        blocks_left_q, blocks_left_d;
  logic                    rd_q, rd_d;
  logic                    asm_clr;
  logic [BLOCK_W-1:0]      asm_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cur_addr_q    <= '0;
      byte_cnt_q    <= '0;
      blocks_left_q <= '0;
      rd_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      byte_cnt_q    <= byte_cnt_d;
      blocks_left_q <= blocks_left_d;
      rd_q          <= rd_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    byte_cnt_d    = byte_cnt_q;
    blocks_left_d = blocks_left_q;
    rd_d          = 1'b0;
    asm_clr       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          asm_clr       = 1'b1;
          cur_addr_d    = base_addr;
          blocks_left_d = num_blocks;
          byte_cnt_d    = '0;
          state_d       = (num_blocks == '0) ? ST_FINISH : ST_FETCH;
        end
      end
      ST_FETCH: begin
        rd_d       = 1'b1;
        cur_addr_d = cur_addr_q + ADDR_W'(1);
        byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
        if (is_last_byte(byte_cnt_q)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (bus.blk_ready) begin
          blocks_left_d = blocks_left_q - CNT_W'(1);
          state_d       = (blocks_left_q == CNT_W'(1)) ? ST_FINISH : ST_FETCH;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides everything, including a same-cycle start, and drops the byte in flight.
    if (abort) begin
      state_d = ST_IDLE;
      rd_d    = 1'b0;
      asm_clr = 1'b1;
    end
  end

  byte_shift_assembler u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (rd_q),
    .din      (bus.mem_data),
    .clr      (asm_clr),
    .dout     (asm_data)
  );

  // Outputs decode from state so an abort or reset blanks them on the next edge.
  assign bus.mem_rd    = (state_q == ST_FETCH);
  assign bus.mem_addr  = (state_q == ST_FETCH) ? cur_addr_q : '0;
  assign bus.blk_valid = (state_q == ST_PRESENT);
  assign bus.blk_data  = (state_q == ST_PRESENT) ? asm_data : '0;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_FINISH);

endmodule

// File: tb/tb_block_fetch_ctrl.sv
// Directed bench for block_fetch_ctrl with a registered byte-memory model.
module tb_block_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] base_addr;
  logic [7:0] num_blocks;
  logic       abort;
  logic       busy;
  logic       done;
  int         total = 0;
  int         bad   = 0;
  logic [7:0] mem [256];

  block_fetch_ctrl_if #(.ADDR_W(8)) bus ();

  block_fetch_ctrl #(.ADDR_W(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .num_blocks (num_blocks),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  // Read data appears the cycle after mem_rd.
  always @(posedge clk) begin
    bus.mem_data <= bus.mem_rd ? mem[bus.mem_addr] : 8'hEE;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  64'(busy), 64'd0);
    check({tag, "_done"},  64'(done), 64'd0);
    check({tag, "_rd"},    64'(bus.mem_rd), 64'd0);
    check({tag, "_addr"},  64'(bus.mem_addr), 64'd0);
    check({tag, "_valid"}, 64'(bus.blk_valid), 64'd0);
    check({tag, "_data"},  bus.blk_data, 64'd0);
  endtask

  task automatic do_start(input logic [7:0] base, input logic [7:0] num);
    base_addr  = base;
    num_blocks = num;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Entered in the first FETCH cycle; returns in the first PRESENT cycle.
  task automatic run_block(input string tag, input logic [7:0] first, input logic [63:0] exp_blk);
    for (int unsigned j = 0; j < 8; j++) begin
      check({tag, "_rd"},   64'(bus.mem_rd), 64'd1);
      check({tag, "_addr"}, 64'(bus.mem_addr), 64'(8'(first + 8'(j))));
      check({tag, "_busy"}, 64'(busy), 64'd1);
      tick();
    end
    check({tag, "_drain_rd"},    64'(bus.mem_rd), 64'd0);
    check({tag, "_drain_valid"}, 64'(bus.blk_valid), 64'd0);
    tick();
    check({tag, "_valid"}, 64'(bus.blk_valid), 64'd1);
    check({tag, "_data"},  bus.blk_data, exp_blk);
  endtask

  initial begin
    for (int unsigned i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    for (int unsigned i = 0; i < 8; i++) begin
      mem[8'h10 + i] = 8'(i);
      mem[8'h18 + i] = 8'h80 + 8'(i);
    end
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; num_blocks = '0;
    bus.blk_ready = 1'b0;
    tick(); tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    // single block, ready tied high
    bus.blk_ready = 1'b1;
    do_start(8'h10, 8'd1);
    run_block("b1", 8'h10, 64'h0001020304050607);
    tick();
    check("b1_done",  64'(done), 64'd1);
    check("b1_fbusy", 64'(busy), 64'd1);
    check("b1_fvalid", 64'(bus.blk_valid), 64'd0);
    tick();
    check("b1_after_done", 64'(done), 64'd0);
    check("b1_after_busy", 64'(busy), 64'd0);

    // two blocks with stalled ready
    bus.blk_ready = 1'b0;
    do_start(8'h10, 8'd2);
    run_block("b2a", 8'h10, 64'h0001020304050607);
    for (int unsigned k = 0; k < 5; k++) begin
      tick();
      check("stall_valid", 64'(bus.blk_valid), 64'd1);
      check("stall_data",  bus.blk_data, 64'h0001020304050607);
      check("stall_rd",    64'(bus.mem_rd), 64'd0);
      check("stall_done",  64'(done), 64'd0);
    end
    bus.blk_ready = 1'b1;
    tick();
    run_block("b2b", 8'h18, 64'h8081828384858687);
    tick();
    check("b2_done", 64'(done), 64'd1);
    tick();
    check("b2_idle", 64'(busy), 64'd0);

    // address wrap
    do_start(8'hFC, 8'd1);
    run_block("wrap", 8'hFC, 64'hA6A7A4A55A5B5859);
    tick();
    check("wrap_done", 64'(done), 64'd1);
    tick();

    // zero blocks
    do_start(8'h40, 8'd0);
    check("zero_busy", 64'(busy), 64'd1);
    check("zero_done", 64'(done), 64'd1);
    check("zero_rd",   64'(bus.mem_rd), 64'd0);
    tick();
    check("zero_busy2", 64'(busy), 64'd0);
    check("zero_done2", 64'(done), 64'd0);
    check("zero_rd2",   64'(bus.mem_rd), 64'd0);

    // start while busy is ignored
    do_start(8'h10, 8'd1);
    base_addr = 8'h80; num_blocks = 8'd5; start = 1'b1;
    run_block("restart", 8'h10, 64'h0001020304050607);
    start = 1'b0;
    tick();
    check("restart_done", 64'(done), 64'd1);
    tick();
    check("restart_idle", 64'(busy), 64'd0);
    tick();
    check("restart_idle2", 64'(busy), 64'd0);
    check("restart_rd", 64'(bus.mem_rd), 64'd0);

    // asynchronous reset at byte 4
    do_start(8'h10, 8'd1);
    tick(); tick(); tick(); tick();
    check("rst_byte4_addr", 64'(bus.mem_addr), 64'h14);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_async");
    tick();
    check_idle_outputs("rst_hold");
    rst_n = 1'b1;
    tick();
    check_idle_outputs("rst_release");

    // abort in PRESENT
    bus.blk_ready = 1'b0;
    do_start(8'h10, 8'd1);
    run_block("abort", 8'h10, 64'h0001020304050607);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle_outputs("abort_next");
    tick();
    check("abort_no_done", 64'(done), 64'd0);

    // start and abort together in IDLE
    base_addr = 8'h10; num_blocks = 8'd1; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 64'(busy), 64'd0);
    check("start_abort_rd",   64'(bus.mem_rd), 64'd0);

    // fresh start after abort
    bus.blk_ready = 1'b1;
    do_start(8'h18, 8'd1);
    run_block("fresh", 8'h18, 64'h8081828384858687);
    tick();
    check("fresh_done", 64'(done), 64'd1);
    tick();
    check("fresh_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
